// File: rtl/ram_reg_mod_controller_if.sv
// Request/response bundle between the processor memory-interface logic and the
// word-register RAM controller.
interface ram_reg_mod_controller_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 9
);
    logic                     read;
    logic                     write;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0]    data_in;
    logic [DATA_WIDTH-1:0]    data_out;
    logic                     complete;
    logic                     busy;
    logic                     addr_err;

    modport master (
        output read, write, address, data_in,
        input  data_out, complete, busy, addr_err
    );

    modport slave (
        input  read, write, address, data_in,
        output data_out, complete, busy, addr_err
    );
endinterface

// File: rtl/ram_reg_mod_controller.sv
// Word-addressed RAM of MEM_SIZE enable-gated registers with an IDLE/ACCESS/DONE
// access controller. Define RAM_CLR_MEM_EN to make clr also zero the storage.
module ram_reg_mod_controller #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 9,
    parameter int MEM_SIZE      = 512
) (
    input  logic                     Clock,
    input  logic                     clr,
    ram_reg_mod_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // One extra bit so MEM_SIZE == 2^ADDRESS_WIDTH is representable.
    localparam logic [ADDRESS_WIDTH:0] MEM_LIMIT = (ADDRESS_WIDTH+1)'(MEM_SIZE);

    state_t                   state_q;
    logic                     op_wr_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic [DATA_WIDTH-1:0]    data_out_q;
    logic                     complete_q;
    logic                     busy_q;
    logic                     addr_err_q;

    logic [DATA_WIDTH-1:0]    mem_q [MEM_SIZE];
    logic [MEM_SIZE-1:0]      word_en_d;
    logic [DATA_WIDTH-1:0]    rd_word_d;
    logic                     in_range;

    assign in_range = ({1'b0, addr_q} < MEM_LIMIT);

    always_comb begin
        word_en_d = '0;
        if (state_q == ACCESS && op_wr_q && in_range) begin
            word_en_d[addr_q] = 1'b1;
        end
    end

    always_comb begin
        rd_word_d = '0;
        if (in_range) begin
            rd_word_d = mem_q[addr_q];
        end
    end

    always_ff @(posedge Clock) begin
        if (!clr) begin
            state_q    <= IDLE;
            op_wr_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            data_out_q <= '0;
            complete_q <= 1'b0;
            busy_q     <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            complete_q <= 1'b0;
            addr_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.write || bus.read) begin
                        op_wr_q <= bus.write;
                        addr_q  <= bus.address;
                        data_q  <= bus.data_in;
                        busy_q  <= 1'b1;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!op_wr_q) begin
                        data_out_q <= rd_word_d;
                    end
                    state_q <= DONE;
                end
                DONE: begin
                    complete_q <= 1'b1;
                    addr_err_q <= !in_range;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // A write whose ACCESS edge sees clr low must leave the word untouched.
`ifdef RAM_CLR_MEM_EN
    always_ff @(posedge Clock) begin
        for (int i = 0; i < MEM_SIZE; i++) begin
            if (!clr) begin
                mem_q[i] <= '0;
            end else if (word_en_d[i]) begin
                mem_q[i] <= data_q;
            end
        end
    end
`else
    always_ff @(posedge Clock) begin
        if (clr) begin
            for (int i = 0; i < MEM_SIZE; i++) begin
                if (word_en_d[i]) begin
                    mem_q[i] <= data_q;
                end
            end
        end
    end
`endif

    assign bus.data_out = data_out_q;
    assign bus.complete = complete_q;
    assign bus.busy     = busy_q;
    assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_ram_reg_mod_controller.sv
// Directed bench: a full-size RAM (512 words) and a partial one (300 words)
// share clock and clr; each transaction is checked cycle by cycle.
module tb_ram_reg_mod_controller;

    logic Clock;
    logic clr;

    ram_reg_mod_controller_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(9)) ifb ();
    ram_reg_mod_controller_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(9)) ifs ();

    ram_reg_mod_controller #(.DATA_WIDTH(32), .ADDRESS_WIDTH(9), .MEM_SIZE(512)) u_dut_b (
        .Clock (Clock),
        .clr   (clr),
        .bus   (ifb)
    );

    ram_reg_mod_controller #(.DATA_WIDTH(32), .ADDRESS_WIDTH(9), .MEM_SIZE(300)) u_dut_s (
        .Clock (Clock),
        .clr   (clr),
        .bus   (ifs)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_chk  = 0;
    int n_fail = 0;

    logic        o_cmp, o_busy, o_err;
    logic [31:0] o_dout;
    logic [31:0] last_b, last_s;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sm, input bit rd, input bit wr,
                         input logic [8:0] a, input logic [31:0] d);
        if (sm) begin
            ifs.read = rd; ifs.write = wr; ifs.address = a; ifs.data_in = d;
        end else begin
            ifb.read = rd; ifb.write = wr; ifb.address = a; ifb.data_in = d;
        end
    endtask

    task automatic sample(input bit sm);
        if (sm) begin
            o_cmp = ifs.complete; o_busy = ifs.busy; o_err = ifs.addr_err; o_dout = ifs.data_out;
        end else begin
            o_cmp = ifb.complete; o_busy = ifb.busy; o_err = ifb.addr_err; o_dout = ifb.data_out;
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge of the
    // completion cycle, so consecutive calls are back-to-back (3 cycles apart).
    task automatic txn(input string tag, input bit sm, input bit rd, input bit wr,
                       input logic [8:0] a, input logic [31:0] d, input bit hold,
                       input logic [31:0] exp_rd, input bit exp_err);
        logic [31:0] exp_do;
        if (wr) exp_do = sm ? last_s : last_b;
        else    exp_do = exp_rd;
        drive(sm, rd, wr, a, d);
        @(posedge Clock); @(negedge Clock);
        if (!hold) drive(sm, 1'b0, 1'b0, a, d);
        sample(sm);
        chk({tag, "_busy1"}, 32'(o_busy), 32'd1);
        chk({tag, "_cmp1"},  32'(o_cmp),  32'd0);
        @(posedge Clock); @(negedge Clock);
        sample(sm);
        chk({tag, "_busy2"}, 32'(o_busy), 32'd1);
        chk({tag, "_cmp2"},  32'(o_cmp),  32'd0);
        @(posedge Clock); @(negedge Clock);
        drive(sm, 1'b0, 1'b0, a, d);
        sample(sm);
        chk({tag, "_cmp3"},  32'(o_cmp),  32'd1);
        chk({tag, "_err"},   32'(o_err),  32'(exp_err));
        chk({tag, "_busy3"}, 32'(o_busy), 32'd0);
        chk({tag, "_dout"},  o_dout,      exp_do);
        if (sm) last_s = exp_do;
        else    last_b = exp_do;
    endtask

    initial begin
        clr = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 9'd0, 32'd0);
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        clr = 1'b1;
        sample(1'b0);
        chk("rst_dout", o_dout,       32'd0);
        chk("rst_cmp",  32'(o_cmp),   32'd0);
        chk("rst_busy", 32'(o_busy),  32'd0);
        chk("rst_err",  32'(o_err),   32'd0);
        last_b = 32'd0;
        last_s = 32'd0;
        @(posedge Clock); @(negedge Clock);

        // Basic write/read, adjacent words independent.
        txn("w0",  1'b0, 1'b0, 1'b1, 9'd0, 32'hA5A5_0000, 1'b0, 32'd0, 1'b0);
        txn("r0",  1'b0, 1'b1, 1'b0, 9'd0, 32'd0,         1'b0, 32'hA5A5_0000, 1'b0);
        txn("w4",  1'b0, 1'b0, 1'b1, 9'd4, 32'h4444_4444, 1'b0, 32'd0, 1'b0);
        txn("w5",  1'b0, 1'b0, 1'b1, 9'd5, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b0);
        txn("r5",  1'b0, 1'b1, 1'b0, 9'd5, 32'd0,         1'b0, 32'hDEAD_BEEF, 1'b0);
        txn("r4",  1'b0, 1'b1, 1'b0, 9'd4, 32'd0,         1'b0, 32'h4444_4444, 1'b0);

        // Read and write together: write wins, data_out untouched.
        txn("rw9", 1'b0, 1'b1, 1'b1, 9'd9, 32'h1234_5678, 1'b0, 32'd0, 1'b0);
        txn("r9",  1'b0, 1'b1, 1'b0, 9'd9, 32'd0,         1'b0, 32'h1234_5678, 1'b0);

        // Requests held high while busy must not start extra transactions.
        txn("hw10", 1'b0, 1'b0, 1'b1, 9'd10, 32'hCAFE_F00D, 1'b1, 32'd0, 1'b0);
        txn("hr10", 1'b0, 1'b1, 1'b0, 9'd10, 32'd0,         1'b1, 32'hCAFE_F00D, 1'b0);
        @(posedge Clock); @(negedge Clock);
        sample(1'b0);
        chk("idle_cmp",  32'(o_cmp),  32'd0);
        chk("idle_busy", 32'(o_busy), 32'd0);

        // Reset landing on the ACCESS edge of a write to the top word.
        txn("w511", 1'b0, 1'b0, 1'b1, 9'd511, 32'h1111_1111, 1'b0, 32'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 9'd511, 32'h2222_2222);
        @(posedge Clock); @(negedge Clock);
        drive(1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
        clr = 1'b0;
        @(posedge Clock); @(negedge Clock);
        clr = 1'b1;
        sample(1'b0);
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_cmp",  32'(o_cmp),  32'd0);
        chk("abort_dout", o_dout,      32'd0);
        last_b = 32'd0;
        last_s = 32'd0;
        @(posedge Clock); @(negedge Clock);
        sample(1'b0);
        chk("abort_cmp2", 32'(o_cmp), 32'd0);
        @(posedge Clock); @(negedge Clock);
        sample(1'b0);
        chk("abort_cmp3", 32'(o_cmp), 32'd0);
        txn("r511", 1'b0, 1'b1, 1'b0, 9'd511, 32'd0, 1'b0, 32'h1111_1111, 1'b0);

        // Partial RAM: out-of-range accesses must not alias or wrap.
        txn("s_w144", 1'b1, 1'b0, 1'b1, 9'd144, 32'h0000_0144, 1'b0, 32'd0, 1'b0);
        txn("s_w299", 1'b1, 1'b0, 1'b1, 9'd299, 32'h0000_0299, 1'b0, 32'd0, 1'b0);
        txn("s_w400", 1'b1, 1'b0, 1'b1, 9'd400, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b1);
        txn("s_r299", 1'b1, 1'b1, 1'b0, 9'd299, 32'd0, 1'b0, 32'h0000_0299, 1'b0);
        txn("s_r400", 1'b1, 1'b1, 1'b0, 9'd400, 32'd0, 1'b0, 32'd0, 1'b1);
        txn("s_r144", 1'b1, 1'b1, 1'b0, 9'd144, 32'd0, 1'b0, 32'h0000_0144, 1'b0);
        txn("s_r300", 1'b1, 1'b1, 1'b0, 9'd300, 32'd0, 1'b0, 32'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_reg_mod_controller.md
Name: ram_reg_mod_controller

Overview:
- Word-addressed RAM built from MEM_SIZE enable-gated word registers, plus the controller that sequences accesses to them.
- One request per transaction: the controller latches read/write, address and data, then pulses the selected word's enable for a write or muxes the selected word to data_out for a read.
- Completion is signalled with a one-cycle `complete` pulse.
- Sits between the processor memory-interface logic (MAR/MDR side) and the word storage.

Parameters:
- DATA_WIDTH, 32: word width in bits.
- ADDRESS_WIDTH, 9: address width in bits.
- MEM_SIZE, 512: number of implemented words; must be ≤ 2^ADDRESS_WIDTH.

Ports:
- Clock  in  1  system clock; all state updates on its rising edge.
- clr  in  1  synchronous active-low reset.
- read  in  1  read request, level-sampled in IDLE.
- write  in  1  write request, level-sampled in IDLE.
- address  in  ADDRESS_WIDTH  word address.
- data_in  in  DATA_WIDTH  write data.
- data_out  out  DATA_WIDTH  registered read data.
- complete  out  1  one-cycle pulse marking the end of a transaction.
- busy  out  1  high while a transaction is in progress (state ≠ IDLE).
- addr_err  out  1  high together with `complete` when the latched address is ≥ MEM_SIZE.

Behaviour:
- Reset (clr=0 at a rising edge):
  - state → IDLE; data_out, complete, busy, addr_err → 0.
  - Latched op/address/data → 0; all word enables → 0.
  - Memory contents follow the Optional Feature.
- Word storage: MEM_SIZE registers, each DATA_WIDTH wide with a private enable.
  - A word loads the latched data on the rising edge where its enable is high; otherwise it holds.
  - Word enables are one-hot or all-zero.
- FSM states IDLE → ACCESS → DONE → IDLE.
- IDLE:
  - If write=1 or read=1 at a rising edge: latch op, address and data_in, then go to ACCESS.
  - If both are high, write takes priority and the read is dropped.
  - If neither is high, stay in IDLE.
- ACCESS (exactly one cycle):
  - Write: enable of word[address] is high for this cycle only; the word updates at the end of the cycle.
  - Read: data_out ← word[address] at the end of the cycle.
  - Next state is DONE.
- DONE (exactly one cycle): complete=1; addr_err=1 if the latched address is ≥ MEM_SIZE. Next state is IDLE.
- Latency: request sampled at edge N; complete is high in the cycle following edge N+2, i.e. a 3-cycle transaction.
  - A new request can be sampled at edge N+3 at the earliest.
- read/write are ignored while not in IDLE; no queuing.
- data_out holds its last read value through writes and idle cycles; only a read (or reset) changes it.
- Out-of-range address (≥ MEM_SIZE):
  - No word enable is asserted.
  - A read loads data_out with 0.
  - complete still pulses, with addr_err=1.
- Read-after-write to the same address in the next transaction returns the new data.
- Reset asserted mid-transaction:
  - The transaction is aborted, no complete pulse is produced, and FSM returns to IDLE.
  - A write whose ACCESS edge coincides with clr=0 does not modify memory.
- Address width rule: the address is compared at full ADDRESS_WIDTH with no truncation or wrap; address 2^ADDRESS_WIDTH−1 is legal when MEM_SIZE = 2^ADDRESS_WIDTH.

Optional Feature:
- Macro RAM_CLR_MEM_EN.
- When defined: clr=0 also clears every storage word to 0.
- When undefined: clr resets only control state and outputs; storage words keep their contents across reset, and are unknown after power-up until written.

Test Plan:
- Reset, then read address 0 with RAM_CLR_MEM_EN defined → data_out=0x00000000, complete pulses 1 cycle at request+2, addr_err=0.
- Write 0xDEADBEEF to address 5, then read 5 → data_out=0xDEADBEEF; an adjacent read of address 4 is unchanged.
- read=1 and write=1 together with address 9 and data 0x12345678 → treated as a write; a subsequent read of 9 returns 0x12345678 and data_out was not changed by the first transaction.
- Request pulses asserted while busy=1 → ignored; exactly one complete per accepted request; back-to-back requests give complete every 3 cycles.
- MEM_SIZE=300 with ADDRESS_WIDTH=9, write 0xFFFFFFFF to address 400 then read 400 → no storage change, read returns 0, addr_err=1 with each complete.
- Write to address 511, and clr=0 asserted during ACCESS → no complete pulse, busy=0 next cycle; a following read of 511 returns the old value.
